// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared encodings for the multi-cycle MIPS control sequencer.
//   - state_e   : sequencer states (IF..ILL, 13-15 unused)
//   - iclass_e  : instruction class produced by mcpu_opdec
//   - opcode / func constants, ALUOp, ALUSrcB, PCSrc, RegDst, MemtoReg codes
//   - dispatch(): ID-state next-state selection from the instruction class
package mcpu_pkg;

    typedef enum logic [3:0] {
        StIf  = 4'd0,
        StId  = 4'd1,
        StExr = 4'd2,
        StExi = 4'd3,
        StExm = 4'd4,
        StMrd = 4'd5,
        StMwr = 4'd6,
        StWbr = 4'd7,
        StWbi = 4'd8,
        StWbm = 4'd9,
        StBr  = 4'd10,
        StJmp = 4'd11,
        StIll = 4'd12
    } state_e;

    typedef enum logic [3:0] {
        ClsRtype,
        ClsJr,
        ClsImm,
        ClsLw,
        ClsSw,
        ClsBeq,
        ClsBne,
        ClsJ,
        ClsJal,
        ClsIll
    } iclass_e;

    // Opcodes (IR[31:26]) and the one func code the sequencer cares about.
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] FuncJr  = 6'h08;

    // ALUOp
    localparam logic [2:0] AluAdd  = 3'd0;
    localparam logic [2:0] AluSub  = 3'd1;
    localparam logic [2:0] AluFunc = 3'd2;
    localparam logic [2:0] AluAnd  = 3'd3;
    localparam logic [2:0] AluOr   = 3'd4;
    localparam logic [2:0] AluSlt  = 3'd5;
    localparam logic [2:0] AluLui  = 3'd6;

    // ALUSrcB
    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    // PCSrc
    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;
    localparam logic [1:0] PcReg    = 2'b11;

    // RegDst
    localparam logic [1:0] DstRt = 2'b00;
    localparam logic [1:0] DstRd = 2'b01;
    localparam logic [1:0] DstRa = 2'b10;

    // MemtoReg
    localparam logic [1:0] WbAlu = 2'b00;
    localparam logic [1:0] WbMdr = 2'b01;
    localparam logic [1:0] WbPc  = 2'b10;

    function automatic state_e dispatch(input iclass_e cls);
        case (cls)
            ClsRtype:            return StExr;
            ClsJr, ClsJ, ClsJal: return StJmp;
            ClsImm:              return StExi;
            ClsLw, ClsSw:        return StExm;
            ClsBeq, ClsBne:      return StBr;
            default:             return StIll;
        endcase
    endfunction

endpackage

// File: rtl/multi_ctrl_if.sv
// multi_ctrl_if: controller <-> datapath bundle.
//   master (controller): takes op/func/mem_ready/zero, drives all control strobes,
//                        instr_done, illegal and the debug state.
//   slave  (datapath)  : the mirror image.
interface multi_ctrl_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       mem_ready;
    logic       zero;
    logic       PCWr;
    logic       PCWrCond;
    logic       BranchNe;
    logic       IorD;
    logic       MemRd;
    logic       MemWr;
    logic       IRWr;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       RegWr;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic [2:0] ALUOp;
    logic [1:0] PCSrc;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, func, mem_ready, zero,
        output PCWr, PCWrCond, BranchNe, IorD, MemRd, MemWr, IRWr, RegDst, MemtoReg,
               RegWr, ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSrc, instr_done, illegal, state
    );

    modport slave (
        output op, func, mem_ready, zero,
        input  PCWr, PCWrCond, BranchNe, IorD, MemRd, MemWr, IRWr, RegDst, MemtoReg,
               RegWr, ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSrc, instr_done, illegal, state
    );
endinterface

// File: rtl/mcpu_opdec.sv
// mcpu_opdec: combinational instruction classifier.
//   op, func  : IR[31:26], IR[5:0]
//   iclass    : instruction class (ClsIll for anything unsupported)
//   imm_aluop : ALU operation for I-type arithmetic/logic
//   imm_sext  : 1 sign-extend, 0 zero-extend (andi/ori) for I-type
module mcpu_opdec
    import mcpu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_e    iclass,
    output logic [2:0] imm_aluop,
    output logic       imm_sext
);

    always_comb begin
        iclass    = ClsIll;
        imm_aluop = AluAdd;
        imm_sext  = 1'b1;
        case (op)
            OpRtype: iclass = (func == FuncJr) ? ClsJr : ClsRtype;
            OpJ:     iclass = ClsJ;
            OpJal:   iclass = ClsJal;
            OpBeq:   iclass = ClsBeq;
            OpBne:   iclass = ClsBne;
            OpAddi, OpAddiu: begin
                iclass    = ClsImm;
                imm_aluop = AluAdd;
            end
            OpSlti: begin
                iclass    = ClsImm;
                imm_aluop = AluSlt;
            end
            OpAndi: begin
                iclass    = ClsImm;
                imm_aluop = AluAnd;
                imm_sext  = 1'b0;
            end
            OpOri: begin
                iclass    = ClsImm;
                imm_aluop = AluOr;
                imm_sext  = 1'b0;
            end
            OpLui: begin
                iclass    = ClsImm;
                imm_aluop = AluLui;
            end
            OpLw:    iclass = ClsLw;
            OpSw:    iclass = ClsSw;
            default: iclass = ClsIll;
        endcase
    end

endmodule

// File: rtl/multi_ctrl.sv
// multi_ctrl: Moore control sequencer for the multi-cycle MIPS datapath.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; also forces every strobe low in the same cycle
//   bus   : multi_ctrl_if.master (op/func/mem_ready/zero in, control strobes out)
// The instruction class is captured in ID so later states do not depend on op/func.
module multi_ctrl
    import mcpu_pkg::*;
(
    input logic          clk,
    input logic          reset,
    multi_ctrl_if.master bus
);

    state_e     state_q;
    iclass_e    cls_q;
    logic [2:0] imm_aluop_q;
    logic       imm_sext_q;

    iclass_e    cls;
    logic [2:0] imm_aluop;
    logic       imm_sext;

    mcpu_opdec u_opdec (
        .op        (bus.op),
        .func      (bus.func),
        .iclass    (cls),
        .imm_aluop (imm_aluop),
        .imm_sext  (imm_sext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIf;
            cls_q       <= ClsIll;
            imm_aluop_q <= AluAdd;
            imm_sext_q  <= 1'b1;
        end else begin
            case (state_q)
                StIf:  if (bus.mem_ready) state_q <= StId;
                StId: begin
                    cls_q       <= cls;
                    imm_aluop_q <= imm_aluop;
                    imm_sext_q  <= imm_sext;
                    state_q     <= dispatch(cls);
                end
                StExr: state_q <= StWbr;
                StExi: state_q <= StWbi;
                StExm: state_q <= (cls_q == ClsLw) ? StMrd : StMwr;
                StMrd: if (bus.mem_ready) state_q <= StWbm;
                StMwr: if (bus.mem_ready) state_q <= StIf;
                default: state_q <= StIf;
            endcase
        end
    end

    always_comb begin
        bus.PCWr       = 1'b0;
        bus.PCWrCond   = 1'b0;
        bus.BranchNe   = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemRd      = 1'b0;
        bus.MemWr      = 1'b0;
        bus.IRWr       = 1'b0;
        bus.RegDst     = DstRt;
        bus.MemtoReg   = WbAlu;
        bus.RegWr      = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = SrcBReg;
        bus.ExtOp      = 1'b0;
        bus.ALUOp      = AluAdd;
        bus.PCSrc      = PcAlu;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        bus.state      = state_q;
        // Gating on reset lets a mid-instruction reset kill pending writes immediately.
        if (!reset) begin
            case (state_q)
                StIf: begin
                    bus.MemRd   = 1'b1;
                    bus.ALUSrcB = SrcBFour;
                    bus.PCWr    = bus.mem_ready;
                    bus.IRWr    = bus.mem_ready;
                end
                StId: begin
                    // Branch target computed speculatively into ALUOut.
                    bus.ALUSrcB = SrcBImmSh;
                    bus.ExtOp   = 1'b1;
                end
                StExr: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = AluFunc;
                end
                StExi: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SrcBImm;
                    bus.ExtOp   = imm_sext_q;
                    bus.ALUOp   = imm_aluop_q;
                end
                StExm: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SrcBImm;
                    bus.ExtOp   = 1'b1;
                end
                StMrd: begin
                    bus.IorD  = 1'b1;
                    bus.MemRd = 1'b1;
                end
                StMwr: begin
                    bus.IorD       = 1'b1;
                    bus.MemWr      = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                StWbr: begin
                    bus.RegDst     = DstRd;
                    bus.RegWr      = 1'b1;
                    bus.instr_done = 1'b1;
                end
                StWbi: begin
                    bus.RegWr      = 1'b1;
                    bus.instr_done = 1'b1;
                end
                StWbm: begin
                    bus.MemtoReg   = WbMdr;
                    bus.RegWr      = 1'b1;
                    bus.instr_done = 1'b1;
                end
                StBr: begin
                    bus.ALUSrcA    = 1'b1;
                    bus.ALUOp      = AluSub;
                    bus.PCWrCond   = 1'b1;
                    bus.PCSrc      = PcAluOut;
                    bus.BranchNe   = (cls_q == ClsBne);
                    bus.instr_done = 1'b1;
                end
                StJmp: begin
                    bus.PCWr       = 1'b1;
                    bus.instr_done = 1'b1;
                    bus.PCSrc      = (cls_q == ClsJr) ? PcReg : PcJump;
                    if (cls_q == ClsJal) begin
                        // PC already holds PC+4, the return address.
                        bus.RegWr    = 1'b1;
                        bus.RegDst   = DstRa;
                        bus.MemtoReg = WbPc;
                    end
                end
                StIll: begin
                    bus.illegal    = 1'b1;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_ctrl.sv
// tb_multi_ctrl: directed + randomized check of multi_ctrl against a per-instruction
// effect model (cycle count, fetches, memory and register writes, PC updates).
module tb_multi_ctrl;
    import mcpu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] st_log[$];

    multi_ctrl_if bus ();

    multi_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [3:0] cycles;
        logic       regwr;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       lw;
        logic       sw;
        logic       jump;
        logic [1:0] jsrc;
        logic       br;
        logic       bne;
        logic       ill;
        logic [1:0] execs;
        logic [2:0] aluop;
        logic       chk_ext;
        logic       ext;
    } exp_t;

    // Architectural effect of one instruction with zero wait states.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] func);
        exp_t e = '0;
        case (op)
            6'h00: begin
                if (func == 6'h08) begin
                    e.cycles = 3; e.jump = 1; e.jsrc = 2'b11;
                end else begin
                    e.cycles = 4; e.regwr = 1; e.regdst = 2'b01; e.execs = 1; e.aluop = 3'd2;
                end
            end
            6'h02: begin e.cycles = 3; e.jump = 1; e.jsrc = 2'b10; end
            6'h03: begin
                e.cycles = 3; e.jump = 1; e.jsrc = 2'b10;
                e.regwr = 1; e.regdst = 2'b10; e.memtoreg = 2'b10;
            end
            6'h04, 6'h05: begin
                e.cycles = 3; e.br = 1; e.bne = (op == 6'h05); e.execs = 1; e.aluop = 3'd1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
                e.cycles = 4; e.regwr = 1; e.execs = 1; e.chk_ext = 1;
                e.ext = !(op == 6'h0C || op == 6'h0D);
                e.aluop = (op == 6'h0A) ? 3'd5 : (op == 6'h0C) ? 3'd3 :
                          (op == 6'h0D) ? 3'd4 : (op == 6'h0F) ? 3'd6 : 3'd0;
            end
            6'h23: begin
                e.cycles = 5; e.lw = 1; e.regwr = 1; e.memtoreg = 2'b01;
                e.execs = 1; e.chk_ext = 1; e.ext = 1;
            end
            6'h2B: begin e.cycles = 4; e.sw = 1; e.execs = 1; e.chk_ext = 1; e.ext = 1; end
            default: begin e.cycles = 3; e.ill = 1; end
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at posedge+1 with the DUT in IF; returns at posedge+1 after instr_done.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] func, input int wif,
                             input int wm, input bit rnd, input string name);
        exp_t e;
        int cyc = 0, dones = 0, irwr = 0, fetch_pc = 0, memrd = 0, memwr = 0, regwr = 0;
        int jumps = 0, brs = 0, ills = 0, execs = 0;
        int lif = wif, lm = wm;
        logic [1:0] regdst = '0, memtoreg = '0, jsrc = '0;
        logic bne = 1'b0, ext = 1'b0;
        logic [2:0] aluop = '0;
        e = model(op, func);
        st_log.delete();
        while (dones == 0 && cyc < 64) begin
            if (bus.state == 4'd0 && rnd) begin
                bus.op   = 6'($urandom);
                bus.func = 6'($urandom);
            end else begin
                bus.op   = op;
                bus.func = func;
            end
            bus.zero = rnd ? 1'($urandom) : 1'b1;
            if (bus.MemRd || bus.MemWr) begin
                if (!bus.IorD) begin
                    bus.mem_ready = (lif == 0);
                    if (lif > 0) lif--;
                end else begin
                    bus.mem_ready = (lm == 0);
                    if (lm > 0) lm--;
                end
            end else begin
                bus.mem_ready = rnd ? 1'($urandom) : 1'b1;
            end
            @(negedge clk);
            cyc++;
            st_log.push_back(bus.state);
            if (bus.IRWr) irwr++;
            if (bus.IRWr && bus.PCWr) fetch_pc++;
            if (bus.MemRd) memrd++;
            if (bus.MemWr) memwr++;
            if (bus.RegWr) begin regwr++; regdst = bus.RegDst; memtoreg = bus.MemtoReg; end
            if (bus.PCWr && !bus.IRWr) begin jumps++; jsrc = bus.PCSrc; end
            if (bus.PCWrCond) begin brs++; bne = bus.BranchNe; end
            if (bus.illegal) ills++;
            if (bus.ALUSrcA) begin execs++; aluop = bus.ALUOp; ext = bus.ExtOp; end
            if (bus.instr_done) dones++;
            @(posedge clk);
            #1;
        end
        check({name, " done"}, dones, 1);
        check({name, " cycles"}, cyc, e.cycles + wif + ((e.lw || e.sw) ? wm : 0));
        check({name, " irwr"}, irwr, 1);
        check({name, " fetch pcwr"}, fetch_pc, 1);
        check({name, " memrd"}, memrd, 1 + wif + (e.lw ? 1 + wm : 0));
        check({name, " memwr"}, memwr, e.sw ? 1 + wm : 0);
        check({name, " regwr"}, regwr, e.regwr);
        if (e.regwr) begin
            check({name, " regdst"}, regdst, e.regdst);
            check({name, " memtoreg"}, memtoreg, e.memtoreg);
        end
        check({name, " jumps"}, jumps, e.jump);
        if (e.jump) check({name, " pcsrc"}, jsrc, e.jsrc);
        check({name, " branches"}, brs, e.br);
        if (e.br) check({name, " branchne"}, bne, e.bne);
        check({name, " illegal"}, ills, e.ill);
        check({name, " execs"}, execs, e.execs);
        if (e.execs != 0) check({name, " aluop"}, aluop, e.aluop);
        if (e.chk_ext) check({name, " extop"}, ext, e.ext);
        check({name, " back to IF"}, bus.state, 0);
    endtask

    logic [5:0] op_tab[17] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                              6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h01, 6'h10};

    initial begin
        logic [5:0] rop, rfunc;
        int k;
        bus.op = '0;
        bus.func = '0;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset strobes", {bus.PCWr, bus.PCWrCond, bus.MemRd, bus.MemWr, bus.IRWr,
                                bus.RegWr, bus.instr_done, bus.illegal}, 0);
        check("reset state", bus.state, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("first fetch memrd", bus.MemRd, 1);
        check("first fetch no done", bus.instr_done, 0);
        @(posedge clk);
        #1;

        // Directed cases
        run_instr(6'h00, 6'h20, 0, 0, 1'b0, "add");
        check("add seq len", st_log.size(), 4);
        if (st_log.size() == 4) begin
            check("add st0", st_log[0], 0);
            check("add st1", st_log[1], 1);
            check("add st2", st_log[2], 2);
            check("add st3", st_log[3], 7);
        end
        run_instr(6'h23, 6'h00, 0, 2, 1'b0, "lw");
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, "beq");
        run_instr(6'h05, 6'h00, 0, 0, 1'b0, "bne");
        run_instr(6'h03, 6'h00, 0, 0, 1'b0, "jal");
        run_instr(6'h00, 6'h08, 0, 0, 1'b0, "jr");
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0, "ill");
        run_instr(6'h2B, 6'h00, 1, 1, 1'b0, "sw");

        // Randomized instruction stream with random wait states
        for (int i = 0; i < 60; i++) begin
            rop = op_tab[$urandom_range(0, 16)];
            rfunc = 6'($urandom);
            if (rop == 6'h00) rfunc = ($urandom_range(0, 3) == 0) ? 6'h08 :
                                      ((rfunc == 6'h08) ? 6'h20 : rfunc);
            run_instr(rop, rfunc, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1,
                      $sformatf("rnd%0d op%02h", i, rop));
        end

        // Reset in the middle of a store wait
        bus.op = 6'h2B;
        bus.func = 6'h00;
        bus.mem_ready = 1'b1;
        k = 0;
        while (bus.state != 4'd6 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("reach MWR", bus.state, 6);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("MWR memwr", bus.MemWr, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset in MWR memwr", bus.MemWr, 0);
        check("reset in MWR done", bus.instr_done, 0);
        check("reset in MWR regwr", bus.RegWr, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("after reset state", bus.state, 0);
        check("after reset memrd", bus.MemRd, 1);
        @(posedge clk);
        #1;
        run_instr(6'h0D, 6'h00, 2, 0, 1'b0, "ori after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_ctrl.md
# multi_ctrl

Multi-cycle MIPS control sequencer for the multi-cycle CPU datapath. It replaces the single-cycle combinational decoder with a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. Each step drives the shared ALU, memory port, IR, PC and register file through per-state control strobes. Memory wait states use a ready handshake.

## Interface
Parameters:
- none (encodings fixed in `mcpu_pkg`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `op`  in  6  IR[31:26], valid from ID onward
- `func`  in  6  IR[5:0]
- `mem_ready`  in  1  memory completes access this cycle
- `zero`  in  1  ALU zero flag
- `PCWr`  out  1  unconditional PC write
- `PCWrCond`  out  1  PC write if branch taken
- `BranchNe`  out  1  taken = !zero (bne), else zero
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemRd`, `MemWr`  out  1  memory strobes
- `IRWr`  out  1  IR load
- `RegDst`  out  2  00 rt, 01 rd, 10 r31
- `MemtoReg`  out  2  00 ALUOut, 01 MDR, 10 PC
- `RegWr`  out  1  register-file write
- `ALUSrcA`  out  1  0 PC, 1 A
- `ALUSrcB`  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- `ExtOp`  out  1  1 sign-extend, 0 zero-extend
- `ALUOp`  out  3  0 ADD, 1 SUB, 2 FUNC, 3 AND, 4 OR, 5 SLT, 6 LUI
- `PCSrc`  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 A (jr)
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction
- `illegal`  out  1  one-cycle pulse on an unsupported opcode
- `state`  out  4  current state, for debug

## Operation
- Supported instructions: R-type (0x00; jr when func=0x08), j 0x02, jal 0x03, beq 0x04, bne 0x05, addi 0x08, addiu 0x09, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B.
- State 0, IF: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSrc=00.
  - If mem_ready=0, hold IF; PCWr=0 and IRWr=0.
  - If mem_ready=1, PCWr=1, IRWr=1, go to ID.
- State 1, ID: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=ADD (branch target into ALUOut). Dispatch on op:
  - R-type (not jr): EXR
  - jr: JMP
  - addi/addiu/slti/andi/ori/lui: EXI
  - lw/sw: EXM
  - beq/bne: BR
  - j/jal: JMP
  - anything else: ILL
- State 2, EXR: ALUSrcA=1, ALUSrcB=00, ALUOp=FUNC. Go to WBR.
- State 3, EXI: ALUSrcA=1, ALUSrcB=10.
  - ExtOp=0 for andi/ori, 1 otherwise.
  - ALUOp: ADD (addi/addiu), SLT, AND, OR, LUI.
  - Go to WBI.
- State 4, EXM: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=ADD. Go to MRD (lw) or MWR (sw).
- State 5, MRD: IorD=1, MemRd=1. Hold until mem_ready, then go to WBM.
- State 6, MWR: IorD=1, MemWr=1 held until mem_ready. On mem_ready: instr_done, go to IF.
- State 7, WBR: RegDst=01, MemtoReg=00, RegWr=1, instr_done. Go to IF.
- State 8, WBI: RegDst=00, MemtoReg=00, RegWr=1, instr_done. Go to IF.
- State 9, WBM: RegDst=00, MemtoReg=01, RegWr=1, instr_done. Go to IF.
- State 10, BR: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWrCond=1, PCSrc=01, BranchNe=(op==0x05), instr_done. Go to IF.
- State 11, JMP: PCWr=1, instr_done. Go to IF.
  - j/jal: PCSrc=10.
  - jal: additionally RegWr=1, RegDst=10, MemtoReg=10 (PC already holds PC+4).
  - jr: PCSrc=11.
- State 12, ILL: illegal=1, no writes. Go to IF; the instruction is skipped.
- Unlisted states 13-15: go to IF with all strobes 0.
- Outputs are Moore (state plus latched op/func); there is no combinational path from mem_ready to any write strobe except PCWr/IRWr in IF and instr_done in MWR.

## Timing
- While reset=1: all strobes 0; state becomes IF on the next edge. The first fetch asserts MemRd in the cycle after reset falls.
- Reset mid-instruction aborts it. Pending MemWr/RegWr are deasserted in that same cycle.
- Cycles with zero wait:
  - R-type, I-type, sw: 4
  - lw: 5
  - beq/bne, j/jal/jr: 3
  - illegal: 3
- Each cycle with mem_ready=0 in IF, MRD or MWR adds exactly one cycle.
- instr_done fires exactly once per instruction, never during reset.

## Structure
- `mcpu_pkg`: state encodings, opcode and func constants, ALUOp / ALUSrcB / PCSrc / RegDst / MemtoReg encodings.
- Sub-module `mcpu_opdec`: combinational op/func classifier that produces the instruction class and immediate ALUOp. The FSM and output decode live in `multi_ctrl`.

## Test plan
- add (op 0, func 0x20), mem_ready tied 1 -> states 0,1,2,7; RegWr=1 with RegDst=01 in cycle 4; instr_done once.
- lw, mem_ready low 2 cycles in MRD -> 7 cycles total; RegWr=1 with MemtoReg=01 only in WBM.
- beq then bne with zero=1 -> PCWrCond=1 both times; BranchNe 0 then 1; 3 cycles each.
- jal -> JMP asserts PCWr, PCSrc=10, RegWr, RegDst=10, MemtoReg=10; jr (func 0x08) -> PCSrc=11, RegWr=0.
- op 0x3F -> illegal pulse in cycle 3, no write strobes, back to IF.
- reset asserted during MWR -> MemWr low in the same cycle, IF after release.
